au_op_sequencer: RTL
====================

Name: au_op_sequencer

Overview:
- Upstream issue stage for the arithmetic unit (AU): signed-magnitude Q9.14, 24-bit; ADD/SUB/MUL single-cycle, DIV multi-cycle.
- Accepts 11-bit register-to-register instructions over a valid/ready handshake.
- Reads operands from a local register file, drives the AU, and writes results back.
- Provides the Kalman datapath controller with an ordered, one-instruction-in-flight execution engine.

Parameters:
W, 24, data width (sign-magnitude Q9.14)
NREG, 8, register file depth (address width clog2(NREG)=3)
TIMEOUT, 63, max cycles waiting for au_done before abort
CNTW, 16, retire counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept instruction
instr  in  11  {op[10:9], dst[8:6], srcA[5:3], srcB[2:0]}; op 00 ADD, 01 SUB, 10 MUL, 11 DIV
host_we  in  1  host register write strobe
host_waddr  in  3  host write address
host_wdata  in  W  host write data
host_raddr  in  3  host read address
host_rdata  out  W  registered read data
au_start  out  1  AU start
au_R  out  W  AU operand R = rf[srcA]
au_S  out  W  AU operand S = rf[srcB]
au_I  out  W  tied 0
au_ctl_d  out  2  AU opcode
au_result_comb  in  W  AU combinational result
au_result_comb_valid  in  1  AU comb-result valid
au_result  in  W  AU registered result (DIV)
au_done  in  1  AU DIV done
au_busy  in  1  AU busy (monitored only)
busy  out  1  state != IDLE
instr_done  out  1  one-cycle pulse on writeback
err  out  1  sticky error flag
err_clr  in  1  clears err
retire_cnt  out  CNTW  count of completed writebacks, wraps

Behaviour:
- Reset (async, rst_n=0): state IDLE; all rf entries 0.
  - All outputs 0 except instr_ready=1.
  - au_R/au_S/au_ctl_d are 0.
- FSM states: IDLE, ISSUE, WAIT_DIV, CAPTURE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and go to ISSUE.
  - instr_ready is 0 in every other state.
- ISSUE:
  - au_start=1; au_R=rf[srcA], au_S=rf[srcB], au_ctl_d=op. These are held stable from ISSUE until return to IDLE.
  - op!=DIV, au_result_comb_valid=1: at the clock edge, rf[dst]<=au_result_comb, instr_done pulses the next cycle, retire_cnt+1, go to IDLE.
    - Issue-to-issue throughput is 2 cycles.
  - op!=DIV, au_result_comb_valid=0: no write, err<=1, go to IDLE.
  - op==DIV: clear wait counter, go to WAIT_DIV.
- WAIT_DIV:
  - au_start=0; the counter increments each cycle.
  - On au_done=1, go to CAPTURE.
  - If the counter reaches TIMEOUT with no done: err<=1, no write, no retire, go to IDLE.
- CAPTURE: rf[dst]<=au_result (the one-cycle settle after done); instr_done pulses; retire_cnt+1; go to IDLE.
- srcA/srcB/dst may alias; operands are read before writeback, so r1=r1*r1 is legal.
- Host write: accepted in any state.
  - If it targets the same address as an engine writeback in the same cycle, the engine write wins and the host write is dropped.
  - Different addresses: both writes occur.
- host_rdata = rf[host_raddr], registered with 1-cycle latency; reflects writes completed at the previous edge.
- err_clr: err<=0, unless a new error occurs in the same cycle, in which case set wins.
- retire_cnt wraps from 2^CNTW-1 to 0.
- Reset mid-DIV: immediately IDLE; rf cleared; no instr_done. The AU shares rst_n.
- No arithmetic is performed locally; values pass through unmodified.

Test Plan:
1. Host loads r1=0x008000 (2.0), r2=0x00C000 (3.0); issue ADD r3,r1,r2.
   -> au_start high for exactly 1 cycle; r3=0x014000 (5.0); instr_done 2 cycles after accept; retire_cnt=1.
2. MUL r4,r1,r2 then SUB r5,r1,r2, issued back-to-back.
   -> r4=0x018000 (6.0); r5=0x804000 (-1.0); instr_ready low only during ISSUE.
3. DIV r6,r1,r2 with the real AU.
   -> r6 within 1% of 0x002AAA (0.6667); busy high until CAPTURE (~26 cycles); instr_ready=0 throughout; au_R/au_S held.
4. Stub AU never asserts done on a DIV into r7 (preloaded 0x001234).
   -> err=1 after TIMEOUT cycles; r7 still 0x001234; retire_cnt unchanged; then err_clr -> err=0.
5. Host write r3=0x00FFFF in the same cycle as the ADD r3 writeback.
   -> r3=0x014000. Host write r0 in that cycle -> r0=0x00FFFF.
6. Assert rst_n=0 at cycle 10 of a DIV.
   -> busy=0, instr_ready=1, all rf read back 0, retire_cnt=0, no instr_done pulse.

Source files
------------

// File: rtl/au_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : au_op_sequencer
// Purpose  : Issue stage for the sign-magnitude Q9.14 arithmetic unit (AU).
//            Accepts 11-bit register-to-register instructions over a
//            valid/ready handshake, reads both operands from a local register
//            file, drives the AU and writes the result back. At most one
//            instruction is in flight, so retirement is strictly in order.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            instr_valid/ready, instr    - instruction handshake
//                                          {op[10:9], dst[8:6], srcA[5:3], srcB[2:0]}
//            host_we/waddr/wdata         - host register write port
//            host_raddr/rdata            - host register read port (1-cycle latency)
//            au_start, au_R, au_S, au_I,
//            au_ctl_d                    - AU command and operands
//            au_result_comb(_valid)      - AU single-cycle result (ADD/SUB/MUL)
//            au_result, au_done          - AU multi-cycle result (DIV)
//            au_busy                     - AU busy (observed only)
//            busy, instr_done, err,
//            err_clr, retire_cnt         - status, sticky error, retire count
// Revision : 1.0 - initial release
// ============================================================================
module au_op_sequencer #(
  parameter int W       = 24,
  parameter int NREG    = 8,
  parameter int TIMEOUT = 63,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [10:0]     instr,
  input  logic            host_we,
  input  logic [2:0]      host_waddr,
  input  logic [W-1:0]    host_wdata,
  input  logic [2:0]      host_raddr,
  output logic [W-1:0]    host_rdata,
  output logic            au_start,
  output logic [W-1:0]    au_R,
  output logic [W-1:0]    au_S,
  output logic [W-1:0]    au_I,
  output logic [1:0]      au_ctl_d,
  input  logic [W-1:0]    au_result_comb,
  input  logic            au_result_comb_valid,
  input  logic [W-1:0]    au_result,
  input  logic            au_done,
  input  logic            au_busy,
  output logic            busy,
  output logic            instr_done,
  output logic            err,
  input  logic            err_clr,
  output logic [CNTW-1:0] retire_cnt
);

  // Register addresses are carried in 3-bit instruction fields.
  localparam int AW = 3;
  // Wide enough to hold TIMEOUT-1, the last value before the abort.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0]    c_OP_DIV   = 2'b11;
  localparam logic [TW-1:0] c_WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_DIV = 2'd2,
    S_CAPTURE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [W-1:0]      r_rf [NREG];
  logic [AW-1:0]     r_dst;
  logic [W-1:0]      r_au_R;
  logic [W-1:0]      r_au_S;
  logic [1:0]        r_au_ctl;
  logic              r_au_start;
  logic              r_instr_ready;
  logic              r_busy;
  logic              r_instr_done;
  logic              r_err;
  logic [CNTW-1:0]   r_retire_cnt;
  logic [TW-1:0]     r_wait_cnt;
  logic [W-1:0]      r_host_rdata;

  logic              w_eng_we;
  logic [W-1:0]      w_eng_data;
  logic              w_err_set;
  logic              w_accept;
  logic              w_unused;

  // The AU busy flag carries no information the sequencer needs: it already
  // knows when a DIV is outstanding.
  assign w_unused = au_busy;

  assign w_accept = instr_valid && r_instr_ready;

  // Engine writeback: single-cycle ops retire straight out of ISSUE, DIV
  // retires from CAPTURE using the AU's registered result.
  assign w_eng_we   = ((r_state == S_ISSUE) && (r_au_ctl != c_OP_DIV) && au_result_comb_valid)
                   || (r_state == S_CAPTURE);
  assign w_eng_data = (r_state == S_CAPTURE) ? au_result : au_result_comb;

  // Error sources: missing single-cycle result, or DIV done never arrived.
  assign w_err_set = ((r_state == S_ISSUE) && (r_au_ctl != c_OP_DIV) && !au_result_comb_valid)
                  || ((r_state == S_WAIT_DIV) && !au_done && (r_wait_cnt == c_WAIT_LAST));

  // --------------------------------------------------------------------------
  // Register file. The engine write takes priority over a host write to the
  // same entry in the same cycle; writes to different entries both land.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rf[gi] <= '0;
      end else if (w_eng_we && (r_dst == AW'(gi))) begin
        r_rf[gi] <= w_eng_data;
      end else if (host_we && (host_waddr == AW'(gi))) begin
        r_rf[gi] <= host_wdata;
      end
    end
  end

  // Host read port sees the array before this edge's writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_host_rdata <= '0;
    end else begin
      r_host_rdata <= r_rf[host_raddr];
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM. Operands are captured from the register file at accept,
  // which is what makes aliased forms such as r1 = r1 * r1 safe, and they stay
  // frozen on au_R/au_S/au_ctl_d while the instruction is in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_dst         <= '0;
      r_au_R        <= '0;
      r_au_S        <= '0;
      r_au_ctl      <= '0;
      r_au_start    <= 1'b0;
      r_instr_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_instr_done  <= 1'b0;
      r_err         <= 1'b0;
      r_retire_cnt  <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_au_start   <= 1'b0;
      r_instr_done <= 1'b0;
      // A new error in the same cycle as err_clr keeps the flag set.
      r_err        <= w_err_set | (r_err & ~err_clr);
      if (w_eng_we) begin
        r_retire_cnt <= r_retire_cnt + CNTW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dst         <= instr[8:6];
            r_au_ctl      <= instr[10:9];
            r_au_R        <= r_rf[instr[5:3]];
            r_au_S        <= r_rf[instr[2:0]];
            r_au_start    <= 1'b1;
            r_instr_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (r_au_ctl == c_OP_DIV) begin
            r_wait_cnt <= '0;
            r_state    <= S_WAIT_DIV;
          end else begin
            r_instr_done  <= w_eng_we;
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end

        S_WAIT_DIV: begin
          if (au_done) begin
            r_state <= S_CAPTURE;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end

        S_CAPTURE: begin
          // au_result has had a cycle to settle after au_done.
          r_instr_done  <= 1'b1;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end

        default: begin
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign host_rdata  = r_host_rdata;
  assign au_start    = r_au_start;
  assign au_R        = r_au_R;
  assign au_S        = r_au_S;
  assign au_I        = '0;
  assign au_ctl_d    = r_au_ctl;
  assign busy        = r_busy;
  assign instr_done  = r_instr_done;
  assign err         = r_err;
  assign retire_cnt  = r_retire_cnt;

endmodule
`default_nettype wire
